// File: rtl/axi_frame_mem_slave.sv
// axi_frame_mem_slave: AXI4 slave with on-chip frame memory serving single-outstanding INCR write and read bursts
module axi_frame_mem_slave #(
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MEM_DEPTH_LOG2 = 12
) (
   input  logic                        i_axi_clk,
   input  logic                        i_reset,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [3:0]                  s_axi_awid,
   input  logic [7:0]                  s_axi_awlen,
   input  logic [1:0]                  s_axi_awburst,
   input  logic [2:0]                  s_axi_awsize,
   input  logic [2:0]                  s_axi_awprot,
   input  logic [3:0]                  s_axi_awqos,
   input  logic                        s_axi_awlock,
   input  logic [3:0]                  s_axi_awcache,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                        s_axi_wlast,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   output logic [3:0]                  s_axi_bid,
   output logic [1:0]                  s_axi_bresp,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [3:0]                  s_axi_arid,
   input  logic [7:0]                  s_axi_arlen,
   input  logic [1:0]                  s_axi_arburst,
   input  logic [2:0]                  s_axi_arsize,
   input  logic [2:0]                  s_axi_arprot,
   input  logic [3:0]                  s_axi_arqos,
   input  logic                        s_axi_arlock,
   input  logic [3:0]                  s_axi_arcache,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [3:0]                  s_axi_rid,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rlast,
   output logic                        o_slverr_flag
);
   localparam int NB = AXI_DATA_WIDTH / 8;
   localparam int B = $clog2(NB);
   localparam logic [2:0] FULL_SIZE = 3'(B);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   logic [AXI_DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
   w_state_t w_state;
   r_state_t r_state;
   logic [MEM_DEPTH_LOG2-1:0] w_idx, r_idx;
   logic [7:0] w_len, w_cnt, r_len;
   logic [8:0] r_issued;
   logic w_err;
   logic aw_hs, ar_hs, w_hs, w_end, w_mis, aw_bad, ar_bad, r_en;
   logic unused;
   assign s_axi_awready = w_state == W_IDLE;
   assign s_axi_wready = w_state == W_DATA;
   assign s_axi_bvalid = w_state == W_RESP;
   assign s_axi_arready = r_state == R_IDLE;
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign w_hs = s_axi_wvalid && s_axi_wready;
   assign w_end = s_axi_wlast || w_cnt == w_len;
   assign w_mis = s_axi_wlast != (w_cnt == w_len);
   assign aw_bad = s_axi_awburst != 2'b01 || s_axi_awsize != FULL_SIZE;
   assign ar_bad = s_axi_arburst != 2'b01 || s_axi_arsize != FULL_SIZE;
   assign r_en = r_state == R_DATA && (!s_axi_rvalid || s_axi_rready) && r_issued <= {1'b0, r_len};
   assign unused = ^{s_axi_awaddr, s_axi_araddr, s_axi_awprot, s_axi_awqos, s_axi_awlock, s_axi_awcache,
                     s_axi_arprot, s_axi_arqos, s_axi_arlock, s_axi_arcache};
   // write channel: latch the burst, absorb beats until wlast or the beat count runs out, then respond
   always_ff @(posedge i_axi_clk) begin
      if (i_reset) begin
         w_state <= W_IDLE;
         w_idx <= '0;
         w_len <= '0;
         w_cnt <= '0;
         w_err <= 1'b0;
         s_axi_bid <= '0;
         s_axi_bresp <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (aw_hs) begin
               w_idx <= s_axi_awaddr[MEM_DEPTH_LOG2+B-1:B];
               w_len <= s_axi_awlen;
               w_cnt <= '0;
               w_err <= aw_bad;
               s_axi_bid <= s_axi_awid;
               w_state <= W_DATA;
            end
            W_DATA: if (w_hs) begin
               w_idx <= w_idx + MEM_DEPTH_LOG2'(1);
               w_cnt <= w_cnt + 8'(1);
               if (w_end) begin
                  s_axi_bresp <= (w_err || w_mis) ? 2'b10 : 2'b00;
                  w_state <= W_RESP;
               end
            end
            W_RESP: if (s_axi_bready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end
   // byte-masked memory write port; contents survive reset
   always_ff @(posedge i_axi_clk) begin
      if (!i_reset && w_hs)
         for (int i = 0; i < NB; i++)
            if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
   end
   // read channel: synchronous read straight into the output register, advancing only when it may be refilled
   always_ff @(posedge i_axi_clk) begin
      if (i_reset) begin
         r_state <= R_IDLE;
         r_idx <= '0;
         r_len <= '0;
         r_issued <= '0;
         s_axi_rvalid <= 1'b0;
         s_axi_rlast <= 1'b0;
         s_axi_rresp <= '0;
         s_axi_rid <= '0;
         s_axi_rdata <= '0;
      end else begin
         if (ar_hs) begin
            r_idx <= s_axi_araddr[MEM_DEPTH_LOG2+B-1:B];
            r_len <= s_axi_arlen;
            r_issued <= '0;
            s_axi_rresp <= ar_bad ? 2'b10 : 2'b00;
            s_axi_rid <= s_axi_arid;
            r_state <= R_DATA;
         end
         if (r_en) begin
            s_axi_rdata <= mem[r_idx];
            s_axi_rlast <= r_issued == {1'b0, r_len};
            s_axi_rvalid <= 1'b1;
            r_idx <= r_idx + MEM_DEPTH_LOG2'(1);
            r_issued <= r_issued + 9'(1);
         end else if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
         if (s_axi_rvalid && s_axi_rready && s_axi_rlast) r_state <= R_IDLE;
      end
   end
   // sticky error: illegal burst type/size on either channel or a misplaced wlast
   always_ff @(posedge i_axi_clk) begin
      if (i_reset) o_slverr_flag <= 1'b0;
      else if ((aw_hs && aw_bad) || (ar_hs && ar_bad) || (w_hs && w_mis)) o_slverr_flag <= 1'b1;
   end
endmodule
